multdiv_seq: RTL and testbench

Iterative unsigned multiply/divide unit for the EX stage; it directly produces the 64-bit product and divide results that the HI/LO registers consume. It accepts one `multu`/`divu` operation from ID/EX and computes it one bit per cycle. It holds the result in internal HI/LO registers. It raises `busy` so the hazard logic can stall dependent `mfhi`/`mflo` instructions.

---
 rtl/multdiv_seq.sv | 125 ++++++++++++
 tb/tb_multdiv_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle; owns the HI/LO registers.
// A result lands in HI/LO WIDTH+1 edges after start. Start is ignored while busy. Flush abandons the operation.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic [WIDTH-1:0] wd,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;
  logic               launch;

  // Multiply: acc = {partial product, remaining multiplier bits}; opnd = multiplicand.
  // Divide:   acc = {remainder, dividend bits / quotient bits};  opnd = divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_rem >= {1'b0, opnd_q});
    div_diff = div_rem[WIDTH-1:0] - opnd_q;
    div_next = {(div_ge ? div_diff : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    step     = op_q ? div_next : mul_next;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    launch  = 1'b0;

    case (state_q)
      S_IDLE: launch = start && !flush;
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          hi_d    = step[2*WIDTH-1:WIDTH];
          lo_d    = step[WIDTH-1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        launch  = start && !flush;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_RUN;
      cnt_d   = '0;
      op_d    = op;
      acc_d   = {{WIDTH{1'b0}}, (op ? a : b)};
      opnd_d  = op ? b : a;
    end

    // mthi/mtlo in DONE land one edge after the result, so they naturally win.
    if (state_q != S_RUN) begin
      if (hi_we) hi_d = wd;
      if (lo_we) lo_d = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: vector table plus hand-written flush/reset/back-to-back sequences.
module tb_multdiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op, flush, hi_we, lo_we;
  logic [31:0] a, b, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  multdiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wd(wd), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives start for one edge; returns at the negedge just after the sampling edge.
  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called from the first negedge after launch; returns at the negedge where done is seen.
  task automatic wait_done(output int cyc, output int nbusy);
    int overlap;
    cyc = 0; nbusy = 0; overlap = 0;
    while (!done && cyc < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
      if (busy && done) overlap++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("busy_done_overlap", overlap, 0);
  endtask

  task automatic expect_no_done(input int ncyc, input string name);
    int seen;
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int cyc, nbusy;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[2] = '{1'b1, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF};
    vecs[3] = '{1'b0, 32'd3,        32'd5,        32'd0,        32'd15};
    vecs[4] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[7] = '{1'b1, 32'd5,        32'd10,       32'd5,        32'd0};
    vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[9] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; a = '0; b = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_start", i), {31'b0, busy}, 1);
      wait_done(cyc, nbusy);
      chk($sformatf("v%0d_busy_cycles", i), nbusy, 32);
      chk($sformatf("v%0d_latency", i), cyc + 1, 33);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 0);
    end

    // mthi in the DONE cycle overrides the fresh result
    launch(1'b0, 32'd4, 32'd5);
    wait_done(cyc, nbusy);
    hi_we = 1'b1; wd = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    chk("done_mthi_hi", hi, 32'h55);
    chk("done_mthi_lo", lo, 32'd20);

    // flush with start in IDLE: nothing launches
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle_busy", {31'b0, busy}, 0);

    // flush 10 cycles into a multiply after mthi/mtlo
    @(negedge clk);
    hi_we = 1'b1; wd = 32'hA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wd = 32'hB;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi_val", hi, 32'hA);
    chk("mtlo_val", lo, 32'hB);
    launch(1'b0, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'b0, busy}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {31'b0, busy}, 0);
    chk("flush_no_done", {31'b0, done}, 0);
    expect_no_done(40, "flush_late_done");
    chk("flush_hi_kept", hi, 32'hA);
    chk("flush_lo_kept", lo, 32'hB);

    // start/mthi mid-RUN ignored, then back-to-back start in DONE
    launch(1'b0, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd3; hi_we = 1'b1; wd = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(cyc, nbusy);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_done(cyc, nbusy);
    chk("b2b_latency", cyc + 1, 33);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd4);

    // reset mid-divide
    launch(1'b1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    expect_no_done(40, "rst_late_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
